// File: rtl/video_pattern_responder_pkg.sv
// Shared video-pipeline definitions: request geometry, RGB565 palette,
// pattern modes and request-field helpers.
package video_pattern_responder_pkg;

  localparam int DEFAULT_CHUNK_BITS = 5;
  localparam int HACTIVE_BITS       = 11;
  localparam int VACTIVE_BITS       = 11;
  localparam int CHUNKNUM_BITS      = HACTIVE_BITS - DEFAULT_CHUNK_BITS;
  localparam int REQUEST_BITS       = VACTIVE_BITS + CHUNKNUM_BITS;
  localparam int BITS_PER_PIXEL     = 16;

  typedef logic [BITS_PER_PIXEL-1:0] rgb565_t;

  localparam rgb565_t COLOR_WHITE   = 16'hFFFF;
  localparam rgb565_t COLOR_YELLOW  = 16'hFFE0;
  localparam rgb565_t COLOR_CYAN    = 16'h07FF;
  localparam rgb565_t COLOR_GREEN   = 16'h07E0;
  localparam rgb565_t COLOR_MAGENTA = 16'hF81F;
  localparam rgb565_t COLOR_RED     = 16'hF800;
  localparam rgb565_t COLOR_BLUE    = 16'h001F;
  localparam rgb565_t COLOR_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    PATTERN_SOLID    = 2'd0,
    PATTERN_BARS     = 2'd1,
    PATTERN_CHECKER  = 2'd2,
    PATTERN_GRADIENT = 2'd3
  } patternMode_t;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_LATCH = 2'd1,
    STATE_EMIT  = 2'd2
  } responderState_t;

  function automatic rgb565_t barColor(input logic [2:0] bar);
    rgb565_t color;
    case (bar)
      3'd0:    color = COLOR_WHITE;
      3'd1:    color = COLOR_YELLOW;
      3'd2:    color = COLOR_CYAN;
      3'd3:    color = COLOR_GREEN;
      3'd4:    color = COLOR_MAGENTA;
      3'd5:    color = COLOR_RED;
      3'd6:    color = COLOR_BLUE;
      default: color = COLOR_BLACK;
    endcase
    return color;
  endfunction

  // Requests are {row, chunkNum} with the row in the MSBs; chunkBits sets the split.
  function automatic logic [HACTIVE_BITS-1:0] requestRow(input logic [31:0] request,
                                                         input int chunkBits);
    return 11'(request >> (HACTIVE_BITS - chunkBits));
  endfunction

  function automatic logic [HACTIVE_BITS-1:0] requestChunk(input logic [31:0] request,
                                                           input int chunkBits);
    return 11'(request & ((32'd1 << (HACTIVE_BITS - chunkBits)) - 32'd1));
  endfunction

endpackage

// File: rtl/video_pattern_responder_pixel.sv
// Combinational test-pattern pixel generator: maps (mode, fill colour, x, y)
// to one RGB565 pixel. Shared by any source that needs synthetic video.
module video_pattern_pixel
  import video_pattern_responder_pkg::*;
#(
  parameter int BAR_SHIFT   = 5,
  parameter int CHECK_SHIFT = 3
) (
  input  patternMode_t                mode,
  input  logic [BITS_PER_PIXEL-1:0]   solidColor,
  input  logic [HACTIVE_BITS-1:0]     x,
  input  logic [VACTIVE_BITS-1:0]     y,
  output logic [BITS_PER_PIXEL-1:0]   pixel
);

  logic [2:0] barIndex;
  logic       checkerWhite;
  logic       unusedBits;

  assign barIndex     = x[BAR_SHIFT+2:BAR_SHIFT];
  assign checkerWhite = x[CHECK_SHIFT] ^ y[CHECK_SHIFT];
  // Not every coordinate bit feeds every pattern; the rest is sunk here.
  assign unusedBits   = ^{x, y};

  always_comb begin
    pixel = solidColor;
    case (mode)
      PATTERN_SOLID:    pixel = solidColor;
      PATTERN_BARS:     pixel = barColor(barIndex);
      PATTERN_CHECKER:  pixel = checkerWhite ? COLOR_WHITE : solidColor;
      PATTERN_GRADIENT: pixel = {x[7:3], y[7:2], x[7:3] ^ y[7:3]};
      default:          pixel = solidColor;
    endcase
  end

endmodule

// File: rtl/video_pattern_responder.sv
// Upstream pixel source: pops {row, chunk} requests and answers each with one
// chunk of test-pattern pixels pushed into the response FIFO.
module video_pattern_responder
  import video_pattern_responder_pkg::*;
#(
  parameter int CHUNK_BITS  = DEFAULT_CHUNK_BITS,
  parameter int BAR_SHIFT   = 5,
  parameter int CHECK_SHIFT = 3
) (
  input  logic                                             sourceClock,
  input  logic                                             reset,
  input  logic [1:0]                                       patternMode,
  input  logic [BITS_PER_PIXEL-1:0]                        solidColor,
  output logic                                             requestFifoReadEnable,
  input  logic                                             requestFifoEmpty,
  input  logic [VACTIVE_BITS+HACTIVE_BITS-CHUNK_BITS-1:0]  requestFifoReadData,
  output logic                                             responseFifoWriteEnable,
  input  logic                                             responseFifoFull,
  output logic [BITS_PER_PIXEL-1:0]                        responseFifoWriteData,
  output logic                                             busy
);

  localparam int LOCAL_CHUNKNUM_BITS = HACTIVE_BITS - CHUNK_BITS;
  localparam logic [CHUNK_BITS-1:0] LAST_PIXEL = '1;

  responderState_t                 state;
  responderState_t                 nextState;
  logic [CHUNK_BITS-1:0]           pixelIndex;
  logic [VACTIVE_BITS-1:0]         rowLatch;
  logic [LOCAL_CHUNKNUM_BITS-1:0]  chunkLatch;
  patternMode_t                    modeLatch;
  logic [BITS_PER_PIXEL-1:0]       colorLatch;
  logic                            readEnable;
  logic                            writeEnable;
  logic [BITS_PER_PIXEL-1:0]       pixel;

  always_comb begin
    nextState   = state;
    readEnable  = 1'b0;
    writeEnable = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (!requestFifoEmpty) begin
          readEnable = 1'b1;
          nextState  = STATE_LATCH;
        end
      end
      STATE_LATCH: begin
        nextState = STATE_EMIT;
      end
      STATE_EMIT: begin
        if (!responseFifoFull) begin
          writeEnable = 1'b1;
          if (pixelIndex == LAST_PIXEL) begin
            nextState = STATE_IDLE;
          end
        end
      end
      default: begin
        nextState = STATE_IDLE;
      end
    endcase
  end

  // Config is captured alongside the request so mid-chunk changes cannot tear a chunk.
  always_ff @(posedge sourceClock or negedge reset) begin
    if (!reset) begin
      state      <= STATE_IDLE;
      pixelIndex <= '0;
      rowLatch   <= '0;
      chunkLatch <= '0;
      modeLatch  <= PATTERN_SOLID;
      colorLatch <= '0;
    end else begin
      state <= nextState;
      if (state == STATE_LATCH) begin
        rowLatch   <= requestRow(32'(requestFifoReadData), CHUNK_BITS);
        chunkLatch <= LOCAL_CHUNKNUM_BITS'(requestChunk(32'(requestFifoReadData), CHUNK_BITS));
        modeLatch  <= patternMode_t'(patternMode);
        colorLatch <= solidColor;
        pixelIndex <= '0;
      end else if (writeEnable) begin
        pixelIndex <= pixelIndex + 1'b1;
      end
    end
  end

  video_pattern_pixel #(
    .BAR_SHIFT   (BAR_SHIFT),
    .CHECK_SHIFT (CHECK_SHIFT)
  ) pixelGen (
    .mode       (modeLatch),
    .solidColor (colorLatch),
    .x          ({chunkLatch, pixelIndex}),
    .y          (rowLatch),
    .pixel      (pixel)
  );

  // State is already IDLE while reset is low, so only the pop needs masking.
  assign requestFifoReadEnable   = readEnable & reset;
  assign responseFifoWriteEnable = writeEnable;
  assign responseFifoWriteData   = writeEnable ? pixel : '0;
  assign busy                    = (state != STATE_IDLE);

endmodule

// File: tb/tb_video_pattern_responder.sv
// Scoreboard bench for video_pattern_responder: requests go through a FIFO
// model, expected pixels come from an arithmetic reference of the patterns.
module tb_video_pattern_responder;

  localparam int CHUNK_SIZE = 32;
  localparam logic [15:0] BAR_TABLE [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef struct {
    int row;
    int chunk;
    int mode;
    int color;
  } request_t;

  logic        sourceClock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  patternMode = 2'd0;
  logic [15:0] solidColor = 16'd0;
  logic        requestFifoReadEnable;
  logic        requestFifoEmpty = 1'b1;
  logic [16:0] requestFifoReadData = 17'd0;
  logic        responseFifoWriteEnable;
  logic        responseFifoFull = 1'b0;
  logic [15:0] responseFifoWriteData;
  logic        busy;

  request_t    reqQ[$];
  logic [15:0] expQ[$];
  int          checks = 0;
  int          failures = 0;
  int          pixInChunk = 0;
  int          fullMode = 0;
  int          stallCnt = 0;
  logic        scrambleNext = 1'b0;

  always #5 sourceClock = ~sourceClock;

  video_pattern_responder dut (
    .sourceClock             (sourceClock),
    .reset                   (reset),
    .patternMode             (patternMode),
    .solidColor              (solidColor),
    .requestFifoReadEnable   (requestFifoReadEnable),
    .requestFifoEmpty        (requestFifoEmpty),
    .requestFifoReadData     (requestFifoReadData),
    .responseFifoWriteEnable (responseFifoWriteEnable),
    .responseFifoFull        (responseFifoFull),
    .responseFifoWriteData   (responseFifoWriteData),
    .busy                    (busy)
  );

  function automatic logic [15:0] refPixel(int mode, int color, int row, int chunk, int idx);
    int x;
    int gx;
    int gy;
    x  = chunk * CHUNK_SIZE + idx;
    gx = (x / 8) % 32;
    gy = (row / 8) % 32;
    case (mode)
      1:       return BAR_TABLE[(x / 32) % 8];
      2:       return (((x / 8) % 2) != ((row / 8) % 2)) ? 16'hFFFF : 16'(color);
      3:       return 16'(gx * 2048 + ((row / 4) % 64) * 32 + (gx ^ gy));
      default: return 16'(color);
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(int row, int chunk, int mode, int color);
    request_t r;
    r.row = row;
    r.chunk = chunk;
    r.mode = mode;
    r.color = color;
    reqQ.push_back(r);
    for (int i = 0; i < CHUNK_SIZE; i++) begin
      expQ.push_back(refPixel(mode, color, row, chunk, i));
    end
  endtask

  task automatic waitDrain(int maxCycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      @(negedge sourceClock);
      #2;
      done = (expQ.size() == 0) && (reqQ.size() == 0) && !busy;
    end
    checkOutput("drained", 32'(done), 32'd1);
  endtask

  // Non-fall-through request FIFO; each request's config is presented with its
  // data, then scrambled once the responder should have latched it.
  always @(posedge sourceClock) begin : fifoModel
    request_t r;
    if (scrambleNext) begin
      patternMode  <= 2'($urandom);
      solidColor   <= 16'($urandom);
      scrambleNext <= 1'b0;
    end
    if (requestFifoReadEnable && reqQ.size() > 0) begin
      r = reqQ.pop_front();
      requestFifoReadData <= {11'(r.row), 6'(r.chunk)};
      patternMode         <= 2'(r.mode);
      solidColor          <= 16'(r.color);
      scrambleNext        <= 1'b1;
    end
    requestFifoEmpty <= (reqQ.size() == 0);
  end

  // Monitor: drives back-pressure, then checks what the DUT presents this cycle.
  initial begin : monitor
    logic [15:0] expected;
    forever begin
      @(negedge sourceClock);
      case (fullMode)
        1: begin
          if (busy && (pixInChunk == 0 || pixInChunk == 15 || pixInChunk == 31) && stallCnt < 3) begin
            responseFifoFull = 1'b1;
            stallCnt++;
          end else begin
            responseFifoFull = 1'b0;
          end
        end
        2:       responseFifoFull = ($urandom_range(0, 3) == 0);
        default: responseFifoFull = 1'b0;
      endcase
      #1;
      if (!reset) begin
        checkOutput("resetReadEnable", 32'(requestFifoReadEnable), 32'd0);
        checkOutput("resetWriteEnable", 32'(responseFifoWriteEnable), 32'd0);
        checkOutput("resetWriteData", 32'(responseFifoWriteData), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        while (pixInChunk != 0 && expQ.size() > 0) begin
          void'(expQ.pop_front());
          pixInChunk = (pixInChunk + 1) % CHUNK_SIZE;
        end
        pixInChunk = 0;
        stallCnt = 0;
      end else begin
        if (responseFifoFull) begin
          checkOutput("noWriteWhileFull", 32'(responseFifoWriteEnable), 32'd0);
        end
        if (requestFifoReadEnable) begin
          checkOutput("noPopWhileBusy", 32'(busy), 32'd0);
        end
        if (responseFifoWriteEnable && !responseFifoFull) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedWrite", 32'd1, 32'd0);
          end else begin
            expected = expQ.pop_front();
            checkOutput($sformatf("pixelData[%0d]", pixInChunk), 32'(responseFifoWriteData), 32'(expected));
          end
          pixInChunk = (pixInChunk + 1) % CHUNK_SIZE;
          stallCnt = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int firstWrite;
    logic hit;
    repeat (3) @(negedge sourceClock);
    reset = 1'b1;
    repeat (2) @(negedge sourceClock);

    // Single bars request from idle: pop pulse, 2-cycle latency, busy timing.
    applyStimulus(0, 0, 1, 0);
    firstWrite = -1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge sourceClock);
      #2;
      if (k == 1) checkOutput("popPulse", 32'(requestFifoReadEnable), 32'd1);
      if (k == 2) checkOutput("popSingle", 32'(requestFifoReadEnable), 32'd0);
      if (responseFifoWriteEnable && firstWrite < 0) firstWrite = k;
      if (k == 34) checkOutput("busyLastPixel", 32'(busy), 32'd1);
      if (k == 35) checkOutput("busyAfterChunk", 32'(busy), 32'd0);
    end
    checkOutput("firstWriteLatency", 32'(firstWrite), 32'd3);
    waitDrain(100);

    applyStimulus(0, 2, 1, 0);
    applyStimulus(0, 7, 1, 0);
    waitDrain(200);
    applyStimulus(8, 0, 2, 16'h1234);
    waitDrain(100);
    applyStimulus(4, 1, 3, 0);
    waitDrain(100);

    // Stalls on first, middle and last pixel with two queued requests.
    fullMode = 1;
    applyStimulus(100, 5, 0, 16'hABCD);
    applyStimulus(2047, 63, 0, 16'h5A5A);
    waitDrain(300);
    fullMode = 0;

    applyStimulus(2047, 63, 3, 0);
    applyStimulus(2047, 63, 1, 0);
    applyStimulus(2047, 63, 2, 16'h0F0F);
    waitDrain(300);

    fullMode = 2;
    for (int n = 0; n < 24; n++) begin
      applyStimulus(int'($urandom_range(0, 2047)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
      repeat ($urandom_range(0, 40)) @(negedge sourceClock);
    end
    waitDrain(4000);
    fullMode = 0;

    // Reset in the middle of a chunk abandons it; the queued request follows.
    applyStimulus(16, 3, 1, 0);
    applyStimulus(9, 4, 2, 16'h0F0F);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge sourceClock);
      #2;
      hit = (pixInChunk == 10) && busy;
    end
    checkOutput("reachedPixel10", 32'(hit), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("resetNowReadEnable", 32'(requestFifoReadEnable), 32'd0);
    checkOutput("resetNowWriteEnable", 32'(responseFifoWriteEnable), 32'd0);
    checkOutput("resetNowWriteData", 32'(responseFifoWriteData), 32'd0);
    checkOutput("resetNowBusy", 32'(busy), 32'd0);
    repeat (2) @(negedge sourceClock);
    reset = 1'b1;
    waitDrain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
